// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg: shared types and helpers for the latch_bank capture register bank.
package latch_bank_pkg;

  // Global capture mode, encoded as on the mode port
  typedef enum logic [1:0] {
    MODE_HOLD    = 2'b00,
    MODE_FOLLOW  = 2'b01,
    MODE_EDGE    = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  // Per-lane one-shot state
  typedef enum logic {
    ST_ARMED  = 1'b0,
    ST_LOCKED = 1'b1
  } os_state_e;

  // Clip an unsigned sum to the largest value representable in w bits.
  function automatic logic [63:0] sat_clip(input logic [63:0] sum, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/latch_bank_lane.sv
// latch_bank_lane: one capture lane (true/complement registers, en history,
// one-shot FSM, capture pulse). Optional parity output under LATCH_BANK_PARITY_EN.
module latch_bank_lane
  import latch_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_en,
  input  logic             i_arm,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_q_b,
  output logic             o_locked,
  output logic             o_cap_pulse,
`ifdef LATCH_BANK_PARITY_EN
  output logic             o_q_par,
`endif
  output logic             o_cap
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_b;
  logic             r_en_prev;
  logic             r_cap_pulse;
  os_state_e        r_state;
  mode_e            w_mode;
  logic             w_cap;

  assign w_mode = mode_e'(i_mode);

  // Decide whether this lane captures on the coming edge
  always_comb begin
    w_cap = 1'b0;
    case (w_mode)
      MODE_FOLLOW:  w_cap = i_en;
      MODE_EDGE:    w_cap = i_en & ~r_en_prev;
      MODE_ONESHOT: w_cap = i_en & (r_state == ST_ARMED);
      default:      w_cap = 1'b0;
    endcase
  end

  // Data registers, en history and capture pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q         <= '0;
      r_q_b       <= '1;
      r_en_prev   <= 1'b0;
      r_cap_pulse <= 1'b0;
    end else begin
      r_en_prev   <= i_en;
      r_cap_pulse <= w_cap;
      if (w_cap) begin
        r_q   <= i_d;
        r_q_b <= ~i_d;
      end
    end
  end

  // One-shot FSM: re-arm wins over capture; arm is honoured in every mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_ARMED;
    end else if (r_state == ST_LOCKED && i_arm) begin
      r_state <= ST_ARMED;
    end else if (w_mode == MODE_ONESHOT && w_cap) begin
      r_state <= ST_LOCKED;
    end
  end

`ifdef LATCH_BANK_PARITY_EN
  logic r_q_par;

  // Even parity of the captured word, updated together with q
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q_par <= 1'b0;
    end else if (w_cap) begin
      r_q_par <= ^i_d;
    end
  end

  assign o_q_par = r_q_par;
`endif

  assign o_q         = r_q;
  assign o_q_b       = r_q_b;
  assign o_locked    = (r_state == ST_LOCKED);
  assign o_cap_pulse = r_cap_pulse;
  assign o_cap       = w_cap;

endmodule

// File: rtl/latch_bank.sv
// latch_bank: CHANNELS synchronous capture lanes plus a saturating global
// capture-event counter. Define LATCH_BANK_PARITY_EN to add q_par/par_chk/par_err.
module latch_bank
  import latch_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       arm,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS*WIDTH-1:0] q_b,
  output logic [CHANNELS-1:0]       locked,
  output logic [CHANNELS-1:0]       cap_pulse,
`ifdef LATCH_BANK_PARITY_EN
  output logic [CHANNELS-1:0]       q_par,
  input  logic [CHANNELS-1:0]       par_chk,
  output logic                      par_err,
`endif
  output logic [CNT_W-1:0]          cap_cnt
);

  // Wide enough that count + all lanes can never wrap before clipping
  localparam int SUM_W = CNT_W + $clog2(CHANNELS) + 1;

  logic [CHANNELS-1:0] w_cap;
  logic [SUM_W-1:0]    w_pop;
  logic [SUM_W-1:0]    w_sum;
  logic [63:0]         w_sat;
  logic [CNT_W-1:0]    r_cap_cnt;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    latch_bank_lane #(.WIDTH(WIDTH)) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_mode      (mode),
      .i_d         (d[gi*WIDTH +: WIDTH]),
      .i_en        (en[gi]),
      .i_arm       (arm[gi]),
      .o_q         (q[gi*WIDTH +: WIDTH]),
      .o_q_b       (q_b[gi*WIDTH +: WIDTH]),
      .o_locked    (locked[gi]),
      .o_cap_pulse (cap_pulse[gi]),
`ifdef LATCH_BANK_PARITY_EN
      .o_q_par     (q_par[gi]),
`endif
      .o_cap       (w_cap[gi])
    );
  end

  // Population count of this cycle's captures
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_pop = w_pop + SUM_W'(w_cap[i]);
    end
  end

  assign w_sum = SUM_W'(r_cap_cnt) + w_pop;
  assign w_sat = sat_clip(64'(w_sum), CNT_W);

  // Saturating capture-event counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cap_cnt <= '0;
    end else begin
      r_cap_cnt <= w_sat[CNT_W-1:0];
    end
  end

  assign cap_cnt = r_cap_cnt;

`ifdef LATCH_BANK_PARITY_EN
  logic [CHANNELS-1:0] w_q_par_now;
  logic                r_par_err;

  always_comb begin
    w_q_par_now = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_q_par_now[i] = ^q[i*WIDTH +: WIDTH];
    end
  end

  // Sticky parity error, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else if (|(par_chk ^ w_q_par_now)) begin
      r_par_err <= 1'b1;
    end
  end

  assign par_err = r_par_err;
`endif

endmodule

// File: tb/tb_latch_bank.sv
// tb_latch_bank: directed-vector bench for latch_bank (default and CNT_W=4 instances).
module tb_latch_bank;

  localparam logic [1:0] M_HOLD    = 2'b00;
  localparam logic [1:0] M_FOLLOW  = 2'b01;
  localparam logic [1:0] M_EDGE    = 2'b10;
  localparam logic [1:0] M_ONESHOT = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [31:0] d;
  logic [3:0]  en;
  logic [3:0]  arm;

  logic [31:0] q, q_b, qs, qs_b;
  logic [3:0]  locked, cap_pulse, locked_s, cap_pulse_s;
  logic [7:0]  cap_cnt;
  logic [3:0]  cap_cnt_s;
`ifdef LATCH_BANK_PARITY_EN
  logic [3:0]  par_chk;
  logic [3:0]  q_par, q_par_s;
  logic        par_err, par_err_s;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  latch_bank #(.WIDTH(8), .CHANNELS(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .d(d), .en(en), .arm(arm),
    .q(q), .q_b(q_b), .locked(locked), .cap_pulse(cap_pulse),
`ifdef LATCH_BANK_PARITY_EN
    .q_par(q_par), .par_chk(par_chk), .par_err(par_err),
`endif
    .cap_cnt(cap_cnt)
  );

  latch_bank #(.WIDTH(8), .CHANNELS(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .mode(mode), .d(d), .en(en), .arm(arm),
    .q(qs), .q_b(qs_b), .locked(locked_s), .cap_pulse(cap_pulse_s),
`ifdef LATCH_BANK_PARITY_EN
    .q_par(q_par_s), .par_chk(par_chk), .par_err(par_err_s),
`endif
    .cap_cnt(cap_cnt_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with busy inputs
    rst_n = 1'b0; mode = M_FOLLOW; d = 32'hA5A5A5A5; en = 4'hF; arm = 4'h0;
`ifdef LATCH_BANK_PARITY_EN
    par_chk = 4'h0;
`endif
    tick(); tick();
    chk("rst_q", q, 32'h0);
    chk("rst_q_b", q_b, 32'hFFFFFFFF);
    chk("rst_locked", locked, 4'h0);
    chk("rst_cap_pulse", cap_pulse, 4'h0);
    chk("rst_cnt", cap_cnt, 8'd0);
    chk("rst_cnt_s", cap_cnt_s, 4'd0);

    // FOLLOW on lane 0
    rst_n = 1'b1; mode = M_FOLLOW; en = 4'b0001; d = 32'hA5A5A53C;
    tick();
    chk("fol_q1", q, 32'h0000003C);
    chk("fol_qb1", q_b, 32'hFFFFFFC3);
    d = 32'hA5A5A55A;
    tick();
    chk("fol_q2", q, 32'h0000005A);
    chk("fol_qb2", q_b, 32'hFFFFFFA5);
    chk("fol_cnt", cap_cnt, 8'd2);
    chk("fol_pulse", cap_pulse, 4'b0001);

    // Switch to EDGE while en0 already high: no capture
    mode = M_EDGE; d = 32'h00000077;
    tick();
    chk("edge_sw_q", q, 32'h0000005A);
    chk("edge_sw_cnt", cap_cnt, 8'd2);
    chk("edge_sw_pulse", cap_pulse, 4'b0000);
    en = 4'b0000;
    tick();

    // EDGE: en0 high five cycles, d0 changing each cycle
    en = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      d = 32'h00000010 + 32'(k);
      tick();
      chk("edge_q", q, 32'h00000010);
      chk("edge_pulse", cap_pulse, (k == 0) ? 4'b0001 : 4'b0000);
    end
    chk("edge_cnt", cap_cnt, 8'd3);
    en = 4'b0000;
    tick();

    // ONESHOT
    mode = M_ONESHOT; en = 4'b0001; d = 32'h00000011;
    tick();
    chk("os_q1", q, 32'h00000011);
    chk("os_lock1", locked, 4'b0001);
    en = 4'b0000;
    tick();
    en = 4'b0001; d = 32'h00000022;
    tick();
    chk("os_q_frozen", q, 32'h00000011);
    chk("os_lock_frozen", locked, 4'b0001);
    arm = 4'b0001; en = 4'b0001; d = 32'h00000099;
    tick();
    chk("os_rearm_lock", locked, 4'b0000);
    chk("os_rearm_q", q, 32'h00000011);
    arm = 4'b0000; en = 4'b0001; d = 32'h00000033;
    tick();
    chk("os_q2", q, 32'h00000033);
    chk("os_lock2", locked, 4'b0001);
    chk("os_cnt", cap_cnt, 8'd5);
    en = 4'b0000;
    mode = M_HOLD; arm = 4'b0001;
    tick();
    chk("hold_arm_lock", locked, 4'b0000);
    arm = 4'b0000;

    // Saturation: all lanes FOLLOW for five cycles
    rst_n = 1'b0;
    tick();
    chk("sat_rst_cnt_s", cap_cnt_s, 4'd0);
    rst_n = 1'b1; mode = M_FOLLOW; en = 4'hF;
    for (int k = 0; k < 5; k++) begin
      d = {4{8'(8'h10 + k)}};
      tick();
      chk("sat_cnt_s", cap_cnt_s, (k < 3) ? 4'(4 * (k + 1)) : 4'd15);
      chk("sat_cnt_wide", cap_cnt, 8'(4 * (k + 1)));
    end
    chk("sat_q", qs, 32'h14141414);

    // HOLD with en high: nothing moves
    mode = M_HOLD; en = 4'hF; d = 32'hDEADBEEF;
    tick(); tick();
    chk("hold_q", q, 32'h14141414);
    chk("hold_q_b", q_b, 32'hEBEBEBEB);
    chk("hold_cnt_s", cap_cnt_s, 4'd15);
    chk("hold_cnt", cap_cnt, 8'd20);
    chk("hold_pulse", cap_pulse, 4'b0000);

`ifdef LATCH_BANK_PARITY_EN
    rst_n = 1'b0; par_chk = 4'h0; en = 4'h0;
    tick();
    chk("par_rst", par_err, 1'b0);
    rst_n = 1'b1; mode = M_FOLLOW; en = 4'b0001; d = 32'h00000007;
    tick();
    chk("par_q_par", q_par, 4'b0001);
    chk("par_err_pre", par_err, 1'b0);
    en = 4'b0000;
    tick();
    chk("par_err_set", par_err, 1'b1);
    par_chk = 4'b0001;
    tick();
    chk("par_err_sticky", par_err, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("par_err_clr", par_err, 1'b0);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
